// File: rtl/shift_tx_serializer_if.sv
// Load handshake and serial-line bundle for shift_tx_serializer.
// The master side owns din/load_valid; the transmitter (slave side) drives everything else.
interface shift_tx_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             dout;
    logic             tx_busy;
    logic             tx_done;

    modport master (
        output din, load_valid,
        input  load_ready, dout, tx_busy, tx_done
    );

    modport slave (
        input  din, load_valid,
        output load_ready, dout, tx_busy, tx_done
    );
endinterface

// File: rtl/shift_tx_serializer.sv
// Parallel-load serial transmitter: one-entry holding register feeding a shift register,
// bit timing from an internal divider, optional start/stop framing, back-to-back frames.
module shift_tx_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int MSB_FIRST    = 0,
    parameter int FRAME        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_tx_serializer_if.slave  bus
);
    localparam int DIV_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    localparam state_e FIRST_STATE = (FRAME != 0) ? START : DATA;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               hold_full_q, hold_full_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               div_last;
    logic               frame_end;
    logic               load_next;

    assign accept   = bus.load_valid && !hold_full_q;
    assign div_last = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        done_d    = 1'b0;
        frame_end = 1'b0;
        load_next = 1'b0;

        case (state_q)
            IDLE: load_next = hold_full_q;
            START: begin
                if (div_last) begin
                    state_d   = DATA;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        if (FRAME != 0) state_d = STOP;
                        else            frame_end = 1'b1;
                    end else begin
                        shreg_d   = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            STOP: begin
                if (div_last) frame_end = 1'b1;
                else          div_cnt_d = div_cnt_q + DIV_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // A waiting word chains straight into the next frame with no idle cycle.
        if (frame_end) begin
            done_d    = 1'b1;
            state_d   = IDLE;
            load_next = hold_full_q;
        end
        if (load_next) begin
            state_d   = FIRST_STATE;
            shreg_d   = hold_q;
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end

        hold_full_d = accept ? 1'b1 : (load_next ? 1'b0 : hold_full_q);
        hold_d      = accept ? bus.din : hold_q;
        busy_d      = (state_d != IDLE);

        // dout is registered, so it is decoded from the state being entered.
        case (state_d)
            START:   dout_d = 1'b0;
            DATA:    dout_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
            default: dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            dout_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign bus.load_ready = !hold_full_q;
    assign bus.dout       = dout_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;
endmodule

// File: tb/tb_shift_tx_serializer.sv
// Bench for shift_tx_serializer: three configurations checked every cycle against a
// frame-timeline model, plus hand-computed literal expectations at chosen cycles.
module tb_shift_tx_serializer;
    localparam int NU = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_tx_serializer_if #(.WIDTH(8)) if0 ();
    shift_tx_serializer_if #(.WIDTH(8)) if1 ();
    shift_tx_serializer_if #(.WIDTH(1)) if2 ();

    shift_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(0), .FRAME(1))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    shift_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1), .FRAME(0))
        dut1 (.clk(clk), .reset(reset), .bus(if1));
    shift_tx_serializer #(.WIDTH(1), .CLKS_PER_BIT(1), .MSB_FIRST(0), .FRAME(1))
        dut2 (.clk(clk), .reset(reset), .bus(if2));

    int cw  [NU] = '{8, 8, 1};
    int cpb [NU] = '{4, 1, 1};
    int cmsb[NU] = '{0, 1, 0};
    int cfr [NU] = '{1, 0, 1};

    logic [7:0] din_v[NU];
    logic       lv[NU];
    logic       a_dout[NU], a_busy[NU], a_done[NU], a_rdy[NU];

    assign if0.din = din_v[0];
    assign if1.din = din_v[1];
    assign if2.din = din_v[2][0:0];
    assign if0.load_valid = lv[0];
    assign if1.load_valid = lv[1];
    assign if2.load_valid = lv[2];
    assign a_dout[0] = if0.dout;  assign a_busy[0] = if0.tx_busy;
    assign a_done[0] = if0.tx_done; assign a_rdy[0] = if0.load_ready;
    assign a_dout[1] = if1.dout;  assign a_busy[1] = if1.tx_busy;
    assign a_done[1] = if1.tx_done; assign a_rdy[1] = if1.load_ready;
    assign a_dout[2] = if2.dout;  assign a_busy[2] = if2.tx_busy;
    assign a_done[2] = if2.tx_done; assign a_rdy[2] = if2.load_ready;

    // Model: each accepted word becomes a frame with a start cycle on a timeline.
    int         cyc = 0;
    bit         rst_seen = 1'b0;
    int         fs[NU][16];
    logic [7:0] fw[NU][16];
    int         nf[NU];
    int         line_free[NU];

    int         n_tests = 0;
    int         n_fail  = 0;

    int         lit_u[128], lit_c[128], lit_k[128];
    logic       lit_v[128];
    int         nlit = 0;

    function automatic int flen(int u);
        return (cw[u] + 2 * cfr[u]) * cpb[u];
    endfunction

    function automatic logic model_ready(int u, int t);
        return !(nf[u] > 0 && fs[u][nf[u]-1] > t);
    endfunction

    task automatic model_out(input int u, input int t,
                             output logic d, output logic b, output logic dn, output logic r);
        d  = 1'b1;
        b  = 1'b0;
        dn = 1'b0;
        r  = model_ready(u, t);
        for (int k = 0; k < nf[u]; k++) begin
            int s;
            s = fs[u][k];
            if (t >= s && t < s + flen(u)) begin
                int j, i;
                b = 1'b1;
                j = (t - s) / cpb[u];
                i = (cfr[u] != 0) ? j - 1 : j;
                if (cfr[u] != 0 && j == 0)              d = 1'b0;
                else if (cfr[u] != 0 && j == cw[u] + 1) d = 1'b1;
                else d = (cmsb[u] != 0) ? fw[u][k][cw[u]-1-i] : fw[u][k][i];
            end
            if (s + flen(u) == t) dn = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            rst_seen = 1'b1;
            for (int u = 0; u < NU; u++) begin
                nf[u] = 0;
                line_free[u] = 0;
            end
        end else begin
            for (int u = 0; u < NU; u++) begin
                if (rst_seen && lv[u] && model_ready(u, cyc) && nf[u] < 16) begin
                    int st;
                    st = (cyc + 2 > line_free[u]) ? cyc + 2 : line_free[u];
                    fs[u][nf[u]] = st;
                    fw[u][nf[u]] = din_v[u];
                    nf[u] = nf[u] + 1;
                    line_free[u] = st + flen(u);
                end
            end
        end
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int u, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d cycle %0d: got %b, expected %b", name, u, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_seen) begin
            for (int u = 0; u < NU; u++) begin
                logic d, b, dn, r;
                model_out(u, cyc, d, b, dn, r);
                check("dout", u, a_dout[u], d);
                check("tx_busy", u, a_busy[u], b);
                check("tx_done", u, a_done[u], dn);
                check("load_ready", u, a_rdy[u], r);
            end
            for (int k = 0; k < nlit; k++) begin
                if (lit_c[k] == cyc) begin
                    case (lit_k[k])
                        0:       check("lit_dout", lit_u[k], a_dout[lit_u[k]], lit_v[k]);
                        1:       check("lit_busy", lit_u[k], a_busy[lit_u[k]], lit_v[k]);
                        2:       check("lit_done", lit_u[k], a_done[lit_u[k]], lit_v[k]);
                        default: check("lit_ready", lit_u[k], a_rdy[lit_u[k]], lit_v[k]);
                    endcase
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // kind: 0 dout, 1 busy, 2 done, 3 ready
    task automatic lit(input int u, input int c, input int kind, input logic v);
        if (nlit < 128) begin
            lit_u[nlit] = u; lit_c[nlit] = c; lit_k[nlit] = kind; lit_v[nlit] = v;
            nlit++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input int u, input logic [7:0] w);
        din_v[u] = w;
        lv[u] = 1'b1;
        tick();
        lv[u] = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    int c0;

    initial begin
        reset = 1'b1;
        for (int u = 0; u < NU; u++) begin
            lv[u] = 1'b0;
            din_v[u] = 8'h00;
        end
        tick();
        do_reset();
        tick();

        // Defaults, 8'hA5 with framing
        c0 = cyc;
        lit(0, c0+1, 3, 1'b0); lit(0, c0+1, 1, 1'b0);
        lit(0, c0+2, 0, 1'b0); lit(0, c0+2, 1, 1'b1); lit(0, c0+2, 3, 1'b1);
        lit(0, c0+5, 0, 1'b0);
        lit(0, c0+6, 0, 1'b1);  lit(0, c0+10, 0, 1'b0); lit(0, c0+14, 0, 1'b1);
        lit(0, c0+18, 0, 1'b0); lit(0, c0+22, 0, 1'b0); lit(0, c0+26, 0, 1'b1);
        lit(0, c0+30, 0, 1'b0); lit(0, c0+34, 0, 1'b1); lit(0, c0+37, 0, 1'b1);
        lit(0, c0+38, 0, 1'b1); lit(0, c0+41, 1, 1'b1);
        lit(0, c0+42, 2, 1'b1); lit(0, c0+42, 1, 1'b0); lit(0, c0+43, 2, 1'b0);
        send(0, 8'hA5);
        wait_until(c0 + 50);

        // MSB first, unframed, one clock per bit
        do_reset();
        tick();
        c0 = cyc;
        lit(1, c0+2, 0, 1'b1); lit(1, c0+3, 0, 1'b0); lit(1, c0+6, 0, 1'b0);
        lit(1, c0+7, 0, 1'b1); lit(1, c0+9, 0, 1'b1); lit(1, c0+9, 1, 1'b1);
        lit(1, c0+10, 2, 1'b1); lit(1, c0+10, 1, 1'b0);
        send(1, 8'hA5);
        wait_until(c0 + 16);

        // Back-to-back frames
        do_reset();
        tick();
        c0 = cyc;
        lit(0, c0+1, 3, 1'b0); lit(0, c0+3, 3, 1'b1); lit(0, c0+4, 3, 1'b0);
        lit(0, c0+41, 3, 1'b0); lit(0, c0+42, 3, 1'b1);
        lit(0, c0+42, 2, 1'b1); lit(0, c0+42, 1, 1'b1); lit(0, c0+42, 0, 1'b0);
        lit(0, c0+82, 2, 1'b1);
        send(0, 8'h0F);
        tick();
        tick();
        send(0, 8'hF0);
        wait_until(c0 + 90);

        // load_valid held high with din changing every cycle
        do_reset();
        tick();
        c0 = cyc;
        lit(0, c0+6, 0, 1'b0);  lit(0, c0+22, 0, 1'b1);
        lit(0, c0+42, 3, 1'b1);
        lit(0, c0+46, 0, 1'b0); lit(0, c0+50, 0, 1'b1);
        lit(0, c0+82, 0, 1'b0); lit(0, c0+86, 0, 1'b0); lit(0, c0+90, 0, 1'b1);
        for (int k = 0; k < 60; k++) begin
            din_v[0] = 8'h30 + 8'(k);
            lv[0] = 1'b1;
            tick();
        end
        lv[0] = 1'b0;
        wait_until(c0 + 130);

        // Reset mid-frame with a second word held
        do_reset();
        tick();
        c0 = cyc;
        lit(0, c0+21, 0, 1'b1); lit(0, c0+21, 1, 1'b0);
        lit(0, c0+21, 3, 1'b1); lit(0, c0+21, 2, 1'b0);
        lit(0, c0+42, 1, 1'b0); lit(0, c0+42, 2, 1'b0); lit(0, c0+60, 0, 1'b1);
        send(0, 8'hC3);
        tick();
        tick();
        send(0, 8'h3C);
        wait_until(c0 + 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_until(c0 + 100);

        // WIDTH=1 boundary, then a chained second frame
        do_reset();
        tick();
        c0 = cyc;
        lit(2, c0+2, 0, 1'b0); lit(2, c0+3, 0, 1'b0); lit(2, c0+4, 0, 1'b1);
        lit(2, c0+4, 1, 1'b1); lit(2, c0+5, 2, 1'b1); lit(2, c0+5, 1, 1'b1);
        lit(2, c0+6, 0, 1'b1); lit(2, c0+8, 2, 1'b1); lit(2, c0+8, 1, 1'b0);
        send(2, 8'h00);
        tick();
        send(2, 8'h01);
        wait_until(c0 + 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
